mips_bus_lsu: RTL and testbench
===============================

MIPS_BUS_LSU -- requirements
Module: mips_bus_lsu

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 0, byte-lane ordering select (0: lane n = addr[1:0]==n; 1: lane n = addr[1:0]==3-n).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have core-side ports: req_valid in 1 request; req_ready out 1 accept; req_we in 1 store when 1; req_size in 2 (BYTE/HALF/WORD); req_signed in 1 sign-extend load; req_addr in 32 byte address; req_wdata in 32 store data, LSB-justified.
REQ-005 SHALL have response ports: rsp_valid out 1 one-cycle pulse; rsp_rdata out 32 extended load data; rsp_err out 1 misaligned access.
REQ-006 SHALL have Avalon master ports: address out 32; read out 1; write out 1; waitrequest in 1; writedata out 32; byteenable out 4; readdata in 32.

Function
REQ-007 SHALL implement FSM states IDLE, BUS, RDATA, RESP.
REQ-008 SHALL assert req_ready only in IDLE; request accepted on edge where req_valid && req_ready.
REQ-009 SHALL, on accept, register request fields; no combinational path from req_* to Avalon outputs.
REQ-010 SHALL flag misaligned: HALF with addr[0]=1, WORD with addr[1:0]!=0, size code 3; go IDLE->RESP with rsp_err=1, rsp_rdata=0, no bus cycle.
REQ-011 SHALL, on aligned accept, go IDLE->BUS; in BUS drive address={addr[31:2],2'b00}, read=!we, write=we, byteenable, writedata.
REQ-012 SHALL hold all Avalon outputs stable while waitrequest=1 (BUS persists, unbounded).
REQ-013 SHALL leave BUS on edge with waitrequest=0: store -> RESP; load -> RDATA.
REQ-014 SHALL deassert read/write outside BUS; address/byteenable/writedata undriven-to-zero outside BUS.
REQ-015 SHALL, in RDATA, capture readdata on that edge, extract selected lane(s), zero/sign-extend per req_signed, go RESP.
REQ-016 SHALL, in RESP, assert rsp_valid for exactly one cycle, then IDLE; load latency accept->rsp_valid = 3 cycles + waitrequest stall cycles; store = 2 + stalls; misaligned = 1.
REQ-017 SHALL generate byteenable: BYTE one-hot lane; HALF 4'b0011 or 4'b1100 (mirrored when BIG_ENDIAN); WORD 4'b1111.
REQ-018 SHALL replicate store data: BYTE wdata[7:0] in all lanes; HALF wdata[15:0] in both halves; WORD unchanged (byte-swapped per lane order when BIG_ENDIAN).
REQ-019 SHALL give rsp_rdata=0 and rsp_err=0 for stores; rsp_rdata/rsp_err hold last value when rsp_valid=0.
REQ-020 SHALL ignore req_valid outside IDLE (no queueing).

Reset
REQ-021 SHALL, on reset low, asynchronously enter IDLE with req_ready=1, read=0, write=0, address=0, byteenable=0, writedata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-022 SHALL abandon any in-flight transfer on reset mid-BUS without generating a response.
REQ-023 SHALL resume normal operation on the first rising edge after reset deasserts.

Structure
REQ-024 SHALL place size enum (BYTE=0,HALF=1,WORD=2) and FSM state enum in shared package mips_bus_pkg.
REQ-025 SHALL factor lane logic (byteenable, writedata replication, load extract/extend) into combinational sub-module mips_lane_align.

Verification
REQ-026 SHALL cover: LB signed addr 0x1003, readdata 0x80FF_0000, BIG_ENDIAN=0 -> byteenable 4'b1000, address 0x1000, rsp_rdata 0xFFFF_FF80.
REQ-027 SHALL cover: SH addr 0x2002, wdata 0x0000_BEEF, waitrequest high 3 cycles -> outputs stable 4 cycles, byteenable 4'b1100, writedata 0xBEEF_BEEF, rsp_valid at cycle 5.
REQ-028 SHALL cover: LW addr 0x3001 -> no read/write asserted, rsp_valid next cycle, rsp_err=1, rsp_rdata=0.
REQ-029 SHALL cover: LHU addr 0x4000, readdata 0x1234_8765 -> rsp_rdata 0x0000_8765; same with req_signed=1 -> 0xFFFF_8765.
REQ-030 SHALL cover: reset low during BUS with waitrequest=1 -> read=0 immediately, no rsp_valid, req_ready=1 after release.
REQ-031 SHALL cover: req_valid held high continuously -> new accept only in IDLE, one rsp_valid per accept.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS load/store unit and its Avalon master.
// Access size codes and FSM state encodings.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BUS   = 2'd1;
  localparam state_t RDATA = 2'd2;
  localparam state_t RESP  = 2'd3;

endpackage

// File: rtl/mips_lane_align.sv
// Byte-lane steering: byteenable, store replication,
// load lane extract and zero/sign extension.
module mips_lane_align
  import mips_bus_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext
);

  logic [1:0]  lane;
  logic [7:0]  b;
  logic [15:0] h;
  logic [15:0] hw;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Big-endian lane n holds address 3-n, i.e. the inverted offset.
  assign lane = BIG_ENDIAN ? ~addr : addr;

  always_comb begin
    be   = 4'b0000;
    wrep = wdata;
    rext = 32'd0;
    b    = 8'd0;
    h    = 16'd0;
    hw   = 16'd0;
    case (size)
      BYTE: begin
        be   = 4'b0001 << lane;
        wrep = {4{wdata[7:0]}};
        b    = rdata[8*lane +: 8];
        rext = {{24{sext & b[7]}}, b};
      end
      HALF: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        hw   = BIG_ENDIAN ? {wdata[7:0], wdata[15:8]}
                          : wdata[15:0];
        wrep = {2{hw}};
        h    = lane[1] ? rdata[31:16] : rdata[15:0];
        if (BIG_ENDIAN) h = {h[7:0], h[15:8]};
        rext = {{16{sext & h[15]}}, h};
      end
      default: begin
        be   = 4'b1111;
        wrep = BIG_ENDIAN ? swap32(wdata) : wdata;
        rext = BIG_ENDIAN ? swap32(rdata) : rdata;
      end
    endcase
  end

endmodule

// File: rtl/mips_bus_lsu.sv
// Single-outstanding load/store unit driving an Avalon-MM master.
// All bus outputs come from registered request fields.
module mips_bus_lsu
  import mips_bus_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  state_t      state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        mis;
  logic        bus;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] rext;

  always_comb begin
    mis = 1'b0;
    case (req_size)
      BYTE:    mis = 1'b0;
      HALF:    mis = req_addr[0];
      WORD:    mis = |req_addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  mips_lane_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .size  (r_size),
    .addr  (r_addr[1:0]),
    .sext  (r_sext),
    .wdata (r_wdata),
    .rdata (readdata),
    .be    (be),
    .wrep  (wrep),
    .rext  (rext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_size    <= 2'd0;
      r_sext    <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_size  <= req_size;
          r_sext  <= req_signed;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          if (mis) begin
            state     <= RESP;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b1;
          end else begin
            state <= BUS;
          end
        end
        BUS: if (!waitrequest) begin
          if (r_we) begin
            state     <= RESP;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end else begin
            state <= RDATA;
          end
        end
        RDATA: begin
          rsp_rdata <= rext;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus        = (state == BUS);
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign read       = bus & ~r_we;
  assign write      = bus & r_we;
  assign address    = bus ? {r_addr[31:2], 2'b00} : 32'd0;
  assign byteenable = bus ? be : 4'b0000;
  assign writedata  = bus ? wrep : 32'd0;

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed bench for mips_bus_lsu (little-endian lanes).
module tb_mips_bus_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int vectors = 0;
  int errs    = 0;
  int accepts = 0;
  int rsps    = 0;

  mips_bus_lsu #(.BIG_ENDIAN(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after accept.
  task automatic send(input logic we, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a,
                      input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = 32'hDEAD_BEEF;
    req_wdata  = 32'hCAFE_F00D;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a,
                         input logic [1:0] sz, input logic sg,
                         input logic [31:0] rd, input logic [3:0] ebe,
                         input logic [31:0] edata);
    waitrequest = 1'b0;
    readdata    = rd;
    send(1'b0, sz, sg, a, 32'd0);
    chk({tag, ".read"}, read, 1);
    chk({tag, ".write"}, write, 0);
    chk({tag, ".addr"}, address, {a[31:2], 2'b00});
    chk({tag, ".be"}, byteenable, ebe);
    chk({tag, ".ready"}, req_ready, 0);
    @(negedge clk);
    chk({tag, ".rdata_read"}, read, 0);
    chk({tag, ".rdata_rspv"}, rsp_valid, 0);
    @(negedge clk);
    chk({tag, ".rspv"}, rsp_valid, 1);
    chk({tag, ".rdata"}, rsp_rdata, edata);
    chk({tag, ".err"}, rsp_err, 0);
    @(negedge clk);
    chk({tag, ".rspv_off"}, rsp_valid, 0);
    chk({tag, ".hold"}, rsp_rdata, edata);
    chk({tag, ".ready_back"}, req_ready, 1);
  endtask

  task automatic do_mis(input string tag, input logic [1:0] sz,
                        input logic [31:0] a);
    send(1'b0, sz, 1'b0, a, 32'd0);
    chk({tag, ".read"}, read, 0);
    chk({tag, ".write"}, write, 0);
    chk({tag, ".rspv"}, rsp_valid, 1);
    chk({tag, ".err"}, rsp_err, 1);
    chk({tag, ".rdata"}, rsp_rdata, 0);
    @(negedge clk);
    chk({tag, ".rspv_off"}, rsp_valid, 0);
    chk({tag, ".ready"}, req_ready, 1);
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    waitrequest = 1'b0;
    readdata    = 32'd0;

    @(negedge clk);
    @(negedge clk);
    chk("rst.ready", req_ready, 1);
    chk("rst.read", read, 0);
    chk("rst.write", write, 0);
    chk("rst.addr", address, 0);
    chk("rst.be", byteenable, 0);
    chk("rst.wdata", writedata, 0);
    chk("rst.rspv", rsp_valid, 0);
    chk("rst.rdata", rsp_rdata, 0);
    chk("rst.err", rsp_err, 0);
    reset = 1'b1;
    @(negedge clk);

    do_load("lb", 32'h0000_1003, 2'd0, 1'b1, 32'h80FF_0000,
            4'b1000, 32'hFFFF_FF80);
    do_mis("lw_mis", 2'd2, 32'h0000_3001);
    do_mis("sz3_mis", 2'd3, 32'h0000_7000);

    // Halfword store stalled three cycles by waitrequest
    waitrequest = 1'b1;
    send(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) begin
        chk("sh.write", write, 1);
        chk("sh.read", read, 0);
        chk("sh.addr", address, 32'h0000_2000);
        chk("sh.be", byteenable, 4'b1100);
        chk("sh.wdata", writedata, 32'hBEEF_BEEF);
      end
      chk("sh.rspv", rsp_valid, (k == 5));
      if (k == 4) waitrequest = 1'b0;
      if (k < 5) @(negedge clk);
    end
    chk("sh.rdata", rsp_rdata, 0);
    chk("sh.err", rsp_err, 0);
    @(negedge clk);
    chk("sh.write_off", write, 0);
    chk("sh.wdata_off", writedata, 0);

    send(1'b1, 2'd0, 1'b0, 32'h0000_8001, 32'h1234_56A5);
    chk("sb.be", byteenable, 4'b0010);
    chk("sb.wdata", writedata, 32'hA5A5_A5A5);
    chk("sb.addr", address, 32'h0000_8000);
    @(negedge clk);
    chk("sb.rspv", rsp_valid, 1);
    @(negedge clk);

    do_load("lhu", 32'h0000_4000, 2'd1, 1'b0, 32'h1234_8765,
            4'b0011, 32'h0000_8765);
    do_load("lh", 32'h0000_4000, 2'd1, 1'b1, 32'h1234_8765,
            4'b0011, 32'hFFFF_8765);
    do_load("lhu_hi", 32'h0000_4002, 2'd1, 1'b0, 32'h1234_8765,
            4'b1100, 32'h0000_1234);
    do_load("lbu1", 32'h0000_4001, 2'd0, 1'b0, 32'h1234_8765,
            4'b0010, 32'h0000_0087);
    do_load("lw", 32'h0000_4004, 2'd2, 1'b1, 32'hF00D_8765,
            4'b1111, 32'hF00D_8765);

    // Reset asserted while the bus is stalled
    waitrequest = 1'b1;
    send(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0);
    chk("rbus.read", read, 1);
    #2 reset = 1'b0;
    #1;
    chk("rbus.read_off", read, 0);
    chk("rbus.addr", address, 0);
    chk("rbus.ready", req_ready, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rbus.rspv", rsp_valid, 0);
    end
    reset = 1'b1;
    waitrequest = 1'b0;
    @(negedge clk);
    chk("rbus.ready_after", req_ready, 1);
    chk("rbus.rspv_after", rsp_valid, 0);
    chk("rbus.read_after", read, 0);

    // Back-to-back word stores with req_valid held high
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h0000_6000;
    req_wdata  = 32'h1122_3344;
    for (int i = 0; i < 9; i++) begin
      chk("cont.ready", req_ready, (i % 3 == 0));
      chk("cont.write", write, (i % 3 == 1));
      chk("cont.rspv", rsp_valid, (i % 3 == 2));
      if (i % 3 == 1) begin
        chk("cont.wdata", writedata, 32'h1122_3344);
        chk("cont.be", byteenable, 4'b1111);
      end
      if (req_valid && req_ready) accepts++;
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("cont.accepts", accepts, 3);
    chk("cont.rsps", rsps, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
